// File: rtl/oc8051_xram_guard.sv
// Access guard between the 8051 core and external RAM: checks page-table
// permissions, forwards allowed accesses, times out stalled ones and reports violations.
module oc8051_xram_guard #(
  parameter logic [7:0] TIMEOUT = 8'd32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_wr,
  input  logic        cpu_stb,
  input  logic        priv_lvl,
  output logic        cpu_ack,
  output logic [7:0]  cpu_data_out,
  input  logic        pt_wr_en,
  input  logic        pt_rd_en,
  input  logic        pt_addr_range,
  input  logic        pt_ack,
  input  logic [7:0]  pt_data_out,
  output logic        pt_stb,
  output logic [15:0] xram_addr,
  output logic [7:0]  xram_data_out,
  output logic        xram_wr,
  output logic        xram_stb,
  input  logic        xram_ack,
  input  logic [7:0]  xram_data_in,
  output logic        fault_irq,
  output logic [15:0] fault_addr,
  output logic        fault_wr,
  output logic [7:0]  fault_cnt,
  input  logic        fault_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PT,
    S_XRAM,
    S_DENY,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       w_perm;
  logic       w_timeout;
  logic       w_fault;
  logic       w_unused;

  // The page-table read completes in a fixed single cycle, so its ack is not needed.
  assign w_unused  = pt_ack;
  assign w_perm    = cpu_wr ? pt_wr_en : pt_rd_en;
  assign w_timeout = (r_state == S_XRAM) && !xram_ack && (r_wait_cnt == TIMEOUT - 8'd1);
  assign w_fault   = (r_state == S_DENY) || w_timeout;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // xram_addr/xram_data_out/xram_wr double as the registered request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 8'd0;
      cpu_ack       <= 1'b0;
      cpu_data_out  <= 8'h00;
      pt_stb        <= 1'b0;
      xram_addr     <= 16'h0000;
      xram_data_out <= 8'h00;
      xram_wr       <= 1'b0;
      xram_stb      <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      pt_stb  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_stb) begin
            xram_addr     <= cpu_addr;
            xram_data_out <= cpu_data_in;
            xram_wr       <= cpu_wr;
            if (pt_addr_range) begin
              if (priv_lvl) begin
                r_state <= S_PT;
                pt_stb  <= 1'b1;
              end else begin
                r_state <= S_DENY;
              end
            end else if (priv_lvl || w_perm) begin
              r_state    <= S_XRAM;
              xram_stb   <= 1'b1;
              r_wait_cnt <= 8'd0;
            end else begin
              r_state <= S_DENY;
            end
          end
        end
        S_PT: begin
          cpu_data_out <= pt_data_out;
          cpu_ack      <= 1'b1;
          r_state      <= S_DONE;
        end
        S_XRAM: begin
          if (xram_ack) begin
            xram_stb     <= 1'b0;
            cpu_data_out <= xram_wr ? 8'h00 : xram_data_in;
            cpu_ack      <= 1'b1;
            r_state      <= S_DONE;
          end else if (w_timeout) begin
            xram_stb     <= 1'b0;
            cpu_data_out <= 8'hFF;
            cpu_ack      <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DENY: begin
          cpu_data_out <= 8'h00;
          cpu_ack      <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A fault arriving together with fault_clr restarts the report from this fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_irq  <= 1'b0;
      fault_addr <= 16'h0000;
      fault_wr   <= 1'b0;
      fault_cnt  <= 8'h00;
    end else if (w_fault) begin
      if (!fault_irq || fault_clr) begin
        fault_addr <= xram_addr;
        fault_wr   <= xram_wr;
      end
      fault_irq <= 1'b1;
      fault_cnt <= fault_clr ? 8'd1 : sat_inc(fault_cnt);
    end else if (fault_clr) begin
      fault_irq <= 1'b0;
      fault_cnt <= 8'h00;
    end
  end

endmodule

// File: tb/tb_oc8051_xram_guard.sv
// Directed, table-driven bench for oc8051_xram_guard with hand-written
// reset sequences around the vector table.
module tb_oc8051_xram_guard;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_wr, cpu_stb, priv_lvl;
  logic        cpu_ack;
  logic [7:0]  cpu_data_out;
  logic        pt_wr_en, pt_rd_en, pt_addr_range, pt_ack;
  logic [7:0]  pt_data_out;
  logic        pt_stb;
  logic [15:0] xram_addr;
  logic [7:0]  xram_data_out;
  logic        xram_wr, xram_stb, xram_ack;
  logic [7:0]  xram_data_in;
  logic        fault_irq;
  logic [15:0] fault_addr;
  logic        fault_wr;
  logic [7:0]  fault_cnt;
  logic        fault_clr;

  oc8051_xram_guard #(.TIMEOUT(8'd32)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_wr(cpu_wr),
    .cpu_stb(cpu_stb), .priv_lvl(priv_lvl),
    .cpu_ack(cpu_ack), .cpu_data_out(cpu_data_out),
    .pt_wr_en(pt_wr_en), .pt_rd_en(pt_rd_en), .pt_addr_range(pt_addr_range),
    .pt_ack(pt_ack), .pt_data_out(pt_data_out), .pt_stb(pt_stb),
    .xram_addr(xram_addr), .xram_data_out(xram_data_out), .xram_wr(xram_wr),
    .xram_stb(xram_stb), .xram_ack(xram_ack), .xram_data_in(xram_data_in),
    .fault_irq(fault_irq), .fault_addr(fault_addr), .fault_wr(fault_wr),
    .fault_cnt(fault_cnt), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr, priv, range, rd_en, wr_en, pre_clr, clr;
    int          ack_dly;
    logic [7:0]  pt_data, xdata;
    int          e_lat;
    logic [7:0]  e_data;
    int          e_stb, e_pt;
    logic        e_irq;
    logic [15:0] e_faddr;
    logic        e_fwr;
    logic [7:0]  e_cnt;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ack_dly = cycles xram_ack stays low after xram_stb rises; >= 255 means never.
  task automatic run_txn(input vec_t v, output int lat, output logic [7:0] data,
                         output int nstb, output int npt, output bit bus_ok, output bit pulse_ok);
    if (v.pre_clr) begin
      @(negedge clk); fault_clr = 1'b1;
      @(negedge clk); fault_clr = 1'b0;
    end
    @(negedge clk);
    cpu_addr = v.addr; cpu_data_in = v.wdata; cpu_wr = v.wr; priv_lvl = v.priv;
    pt_addr_range = v.range; pt_rd_en = v.rd_en; pt_wr_en = v.wr_en;
    pt_data_out = v.pt_data; xram_data_in = v.xdata; cpu_stb = 1'b1;
    lat = 0; data = 8'h00; nstb = 0; npt = 0; bus_ok = 1'b1; pulse_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      cpu_stb   = 1'b0;
      cpu_addr  = ~v.addr;
      fault_clr = (c == 1) && v.clr;
      if (xram_stb) begin
        nstb++;
        if (xram_addr !== v.addr || xram_wr !== v.wr || (v.wr && xram_data_out !== v.wdata))
          bus_ok = 1'b0;
      end
      if (pt_stb) npt++;
      xram_ack = xram_stb && (v.ack_dly < 255) && (nstb > v.ack_dly);
      if (cpu_ack) begin
        lat  = c;
        data = cpu_data_out;
        break;
      end
    end
    xram_ack  = 1'b0;
    fault_clr = 1'b0;
    @(negedge clk);
    if (cpu_ack !== 1'b0 || cpu_data_out !== data) pulse_ok = 1'b0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    int lat, nstb, npt;
    logic [7:0] data;
    bit bus_ok, pulse_ok;
    run_txn(v, lat, data, nstb, npt, bus_ok, pulse_ok);
    chk($sformatf("v%0d latency", idx), lat, v.e_lat);
    chk($sformatf("v%0d data", idx), data, v.e_data);
    chk($sformatf("v%0d xram_stb_cycles", idx), nstb, v.e_stb);
    chk($sformatf("v%0d pt_stb_cycles", idx), npt, v.e_pt);
    chk($sformatf("v%0d xram_bus", idx), bus_ok, 1);
    chk($sformatf("v%0d ack_pulse_hold", idx), pulse_ok, 1);
    chk($sformatf("v%0d fault_irq", idx), fault_irq, v.e_irq);
    chk($sformatf("v%0d fault_addr", idx), fault_addr, v.e_faddr);
    chk($sformatf("v%0d fault_wr", idx), fault_wr, v.e_fwr);
    chk($sformatf("v%0d fault_cnt", idx), fault_cnt, v.e_cnt);
  endtask

  vec_t vecs[12];

  initial begin
    int ack_seen;
    vec_t v;
    // addr wdata wr priv range rd wr_en preclr clr dly ptd xd | lat data stb pt irq faddr fwr cnt
    vecs[0]  = '{16'h0123, 8'h00, 0, 0, 0, 1, 0, 0, 0,   3, 8'h00, 8'h5A,  5, 8'h5A,  4, 0, 0, 16'h0000, 0, 8'd0};
    vecs[1]  = '{16'h0456, 8'h77, 1, 0, 0, 0, 1, 0, 0,   0, 8'h00, 8'hEE,  2, 8'h00,  1, 0, 0, 16'h0000, 0, 8'd0};
    vecs[2]  = '{16'h2345, 8'h99, 1, 0, 0, 1, 0, 0, 0,   0, 8'h00, 8'h00,  2, 8'h00,  0, 0, 1, 16'h2345, 1, 8'd1};
    vecs[3]  = '{16'hFF85, 8'h00, 0, 0, 1, 1, 1, 0, 0,   0, 8'hC3, 8'h00,  2, 8'h00,  0, 0, 1, 16'h2345, 1, 8'd2};
    vecs[4]  = '{16'hFF85, 8'h00, 0, 1, 1, 0, 0, 0, 0,   0, 8'hC3, 8'h00,  2, 8'hC3,  0, 1, 1, 16'h2345, 1, 8'd2};
    vecs[5]  = '{16'h0800, 8'h11, 1, 1, 0, 0, 0, 0, 0,   1, 8'h00, 8'hAB,  3, 8'h00,  2, 0, 1, 16'h2345, 1, 8'd2};
    vecs[6]  = '{16'h0900, 8'h00, 0, 1, 0, 0, 0, 0, 0, 255, 8'h00, 8'h44, 33, 8'hFF, 32, 0, 1, 16'h2345, 1, 8'd3};
    vecs[7]  = '{16'h1000, 8'h00, 0, 0, 0, 0, 1, 1, 0,   0, 8'h00, 8'h00,  2, 8'h00,  0, 0, 1, 16'h1000, 0, 8'd1};
    vecs[8]  = '{16'h2000, 8'h00, 0, 0, 0, 0, 1, 0, 0,   0, 8'h00, 8'h00,  2, 8'h00,  0, 0, 1, 16'h1000, 0, 8'd2};
    vecs[9]  = '{16'h3000, 8'h00, 0, 0, 0, 0, 0, 0, 1,   0, 8'h00, 8'h00,  2, 8'h00,  0, 0, 1, 16'h3000, 0, 8'd1};
    vecs[10] = '{16'hFF90, 8'h00, 0, 0, 1, 1, 1, 0, 0,   0, 8'h00, 8'h00,  2, 8'h00,  0, 0, 1, 16'h3000, 0, 8'd2};
    vecs[11] = '{16'h0123, 8'h00, 0, 1, 0, 0, 0, 0, 0,   0, 8'h00, 8'h81,  2, 8'h81,  1, 0, 1, 16'h3000, 0, 8'd2};

    rst = 1'b0; cpu_addr = 16'h0; cpu_data_in = 8'h0; cpu_wr = 1'b0; cpu_stb = 1'b0;
    priv_lvl = 1'b0; pt_wr_en = 1'b0; pt_rd_en = 1'b0; pt_addr_range = 1'b0; pt_ack = 1'b0;
    pt_data_out = 8'h0; xram_ack = 1'b0; xram_data_in = 8'h0; fault_clr = 1'b0;
    #1;
    chk("reset ctrl", {cpu_ack, pt_stb, xram_stb, xram_wr, fault_irq, fault_wr}, 6'b0);
    chk("reset data", {cpu_data_out, xram_data_out, fault_cnt}, 24'h0);
    chk("reset addr", {xram_addr, fault_addr}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    // Stray acks while idle must not start or disturb anything.
    xram_ack = 1'b1; pt_ack = 1'b1;
    @(negedge clk);
    chk("idle stray ack", {cpu_ack, xram_stb, pt_stb}, 3'b0);
    xram_ack = 1'b0; pt_ack = 1'b0;

    for (int i = 0; i < 12; i++) apply(i, vecs[i]);

    // Reset in the middle of an XRAM access.
    @(negedge clk);
    cpu_addr = 16'h0A00; cpu_wr = 1'b0; priv_lvl = 1'b1; pt_addr_range = 1'b0; cpu_stb = 1'b1;
    @(negedge clk);
    cpu_stb = 1'b0;
    chk("mid xram_stb before reset", xram_stb, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid xram_stb after reset", xram_stb, 0);
    chk("mid fault_cnt after reset", fault_cnt, 0);
    ack_seen = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (cpu_ack) ack_seen++;
      @(negedge clk);
    end
    chk("mid no cpu_ack", ack_seen, 0);
    v = '{16'h0B00, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h3C, 2, 8'h3C, 1, 0, 0, 16'h0000, 0, 8'd0};
    apply(12, v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/oc8051_xram_guard.md
OC8051_XRAM_GUARD -- requirements
Module: oc8051_xram_guard

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd32, meaning the maximum cycles to wait for xram_ack before aborting.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports cpu_addr  in  16, cpu_data_in  in  8, cpu_wr  in  1, cpu_stb  in  1, priv_lvl  in  1: the CPU external-memory request (1 = privileged).
REQ-005 SHALL have ports cpu_ack  out  1 and cpu_data_out  out  8: completion pulse and read data to the CPU.
REQ-006 SHALL have ports pt_wr_en, pt_rd_en, pt_addr_range, pt_ack  in  1 and pt_data_out  in  8: permission, decode and read data from the page table, computed combinationally from cpu_addr.
REQ-007 SHALL have port pt_stb  out  1: strobe to the page table.
REQ-008 SHALL have ports xram_addr  out  16, xram_data_out  out  8, xram_wr  out  1, xram_stb  out  1, xram_ack  in  1, xram_data_in  in  8: the external RAM bus.
REQ-009 SHALL have ports fault_irq  out  1, fault_addr  out  16, fault_wr  out  1, fault_cnt  out  8, fault_clr  in  1: the access-violation report.

Function
REQ-010 SHALL implement the FSM states IDLE, PT, XRAM, DENY and DONE.
REQ-011 In IDLE with cpu_stb=1, the block SHALL register cpu_addr, cpu_data_in and cpu_wr, then select the next state in this priority:
- pt_addr_range=1 and priv_lvl=1 -> PT
- pt_addr_range=1 and priv_lvl=0 -> DENY
- priv_lvl=1, or permission bit set (pt_wr_en if write, pt_rd_en if read) -> XRAM
- otherwise -> DENY
REQ-012 PT SHALL drive pt_stb=1 for exactly one cycle, capture pt_data_out, then go to DONE.
REQ-013 XRAM SHALL hold xram_stb=1 with the registered address, data and wr until xram_ack=1, capture xram_data_in on reads, then go to DONE.
REQ-014 A 8-bit wait counter SHALL clear on XRAM entry and increment each XRAM cycle; when it reaches TIMEOUT without xram_ack, the block SHALL drop xram_stb, set return data 8'hFF, record a fault and go to DONE.
REQ-015 DENY SHALL record a fault, set return data 8'h00, and go to DONE without asserting xram_stb or pt_stb.
REQ-016 DONE SHALL assert cpu_ack for exactly one cycle with cpu_data_out valid, then return to IDLE; cpu_data_out SHALL hold its value until the next DONE.
REQ-017 Latency SHALL be as follows:
- DENY: cpu_ack 2 cycles after acceptance
- PT: 2 cycles
- XRAM: 2 + N cycles, where N is the number of cycles xram_ack stays low
REQ-018 cpu_stb changes after acceptance SHALL be ignored; an accepted transaction always completes.
REQ-019 Fault record: if fault_irq=0, fault_addr and fault_wr SHALL latch the offending address and direction and fault_irq SHALL set; if fault_irq=1, the latched values SHALL stay unchanged.
REQ-020 Every fault SHALL increment fault_cnt, saturating at 8'hFF.
REQ-021 fault_clr=1 SHALL clear fault_irq and fault_cnt next cycle; a fault in the same cycle SHALL win, leaving fault_irq=1, fault_cnt=1 and the new address latched.
REQ-022 xram_ack or pt_ack outside the XRAM or PT states SHALL be ignored.

Reset
REQ-023 rst=0 SHALL immediately force:
- FSM to IDLE
- cpu_ack, pt_stb, xram_stb, xram_wr, fault_irq, fault_wr = 0
- cpu_data_out, xram_data_out, fault_cnt = 0, and xram_addr, fault_addr = 16'h0000
- wait counter = 0
REQ-024 Reset mid-transaction SHALL abort the transaction with no cpu_ack, and the FSM SHALL accept a new request on the first cycle after rst=1.

Verification
REQ-025 User read at 16'h0123 with pt_rd_en=1 and xram_ack asserted 3 cycles after xram_stb -> xram_stb high 4 cycles, cpu_ack pulses with xram_data_in, no fault.
REQ-026 User write at 16'h2345 with pt_wr_en=0 -> no xram_stb, cpu_ack with data 8'h00, fault_irq=1, fault_addr=16'h2345, fault_wr=1, fault_cnt=1.
REQ-027 User access at 16'hFF85 -> DENY and fault; privileged access at 16'hFF85 -> one-cycle pt_stb, cpu_data_out=pt_data_out.
REQ-028 Privileged read with xram_ack held low -> after 32 XRAM cycles cpu_ack with 8'hFF, fault recorded.
REQ-029 Two denied accesses (16'h1000, then 16'h2000) followed by fault_clr coinciding with a third (16'h3000) -> fault_addr=16'h1000 and fault_cnt=2 before the clear, then fault_addr=16'h3000, fault_cnt=1, fault_irq=1.
REQ-030 Assert rst=0 during the XRAM state -> xram_stb=0 immediately, no cpu_ack, next request serviced normally.
